inference_scheduler: RTL and testbench

- Front-end controller for the layered network of weight_comp_cell, relu_cell and softmax_cell stages.
- Collects each input sample element-by-element from a valid/ready stream and replays it into the first layer as one contiguous index/value/enable burst.
- Limits samples in flight with a credit counter, because the network pipeline cannot stall.
- Buffers the softmax outputs in a small FIFO and returns them through a valid/ready result port.

---
 rtl/inference_scheduler_pkg.sv | 25 ++
 rtl/inference_scheduler_result_fifo.sv | 79 +++++++
 rtl/inference_scheduler.sv | 170 +++++++++++++++++
 tb/tb_inference_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inference_scheduler_pkg.sv
// Shared types and constants for the inference front-end scheduler and the
// network cells that produce its result word.
package inference_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LOAD        = 2'd1,
      WAIT_CREDIT = 2'd2,
      BURST       = 2'd3
   } sched_state_e;

   localparam int DATA_WIDTH_DEFAULT = 32;

   // The result valid flag sits just above the class bits, as softmax_cell and relu_cell emit it.
   localparam int RESULT_VALID_BIT = DATA_WIDTH_DEFAULT;

   function automatic int result_valid_bit(input int data_width);
      return data_width;
   endfunction

   function automatic int min_one_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inference_scheduler_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible whenever the
// FIFO is non-empty, and a push and pop may share a cycle even when full.
module result_fifo
   import inference_scheduler_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = min_one_clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign head_data = mem_q[rd_ptr_q];

   // When full, a write is only allowed because the simultaneous pop frees the slot it lands in.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/inference_scheduler.sv
// Front-end controller: gathers a sample from the input stream, replays it as a
// contiguous burst into layer 1 under credit control, and queues the results.
module inference_scheduler
   import inference_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
   parameter int INPUT_AMOUNT  = 4,
   parameter int MAX_IN_FLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_value,
   output logic [DATA_WIDTH-1:0] net_index,
   output logic [DATA_WIDTH-1:0] net_value,
   output logic                  net_enable,
   input  logic [DATA_WIDTH:0]   net_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_class,
   output logic                  busy,
   output logic                  err_unexpected
);

   localparam int CNT_W     = min_one_clog2(INPUT_AMOUNT);
   localparam int CRED_W    = $clog2(MAX_IN_FLIGHT + 1);
   localparam int VALID_BIT = result_valid_bit(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(INPUT_AMOUNT - 1);
   localparam logic [CRED_W-1:0] FULL_CREDITS = CRED_W'(MAX_IN_FLIGHT);

   sched_state_e          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CRED_W-1:0]     credits_q, credits_d;
   logic [DATA_WIDTH-1:0] buffer_q [INPUT_AMOUNT];
   logic [DATA_WIDTH-1:0] buffer_d [INPUT_AMOUNT];
   logic                  in_ready_q, in_ready_d;
   logic                  net_enable_q, net_enable_d;
   logic [DATA_WIDTH-1:0] net_index_q, net_index_d;
   logic [DATA_WIDTH-1:0] net_value_q, net_value_d;
   logic                  err_q, err_d;

   logic                  in_fire;
   logic                  take_credit;
   logic                  result_valid;
   logic                  nothing_outstanding;
   logic                  drop_result;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;

   assign in_fire      = in_valid && in_ready_q;
   assign result_valid = net_result[VALID_BIT];
   assign fifo_pop     = out_ready && !fifo_empty;

   // A result with no credit out and nothing queued is stale network state (e.g. after a reset).
   assign nothing_outstanding = (credits_q == FULL_CREDITS) && fifo_empty;
   assign drop_result = result_valid && (nothing_outstanding || (fifo_full && !fifo_pop));
   assign fifo_push   = result_valid && !drop_result;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      buffer_d     = buffer_q;
      take_credit  = 1'b0;
      net_enable_d = 1'b0;
      net_index_d  = net_index_q;
      net_value_d  = net_value_q;
      case (state_q)
         IDLE, LOAD: begin
            if (in_fire) begin
               buffer_d[cnt_q] = in_value;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = WAIT_CREDIT;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = LOAD;
               end
            end
         end
         WAIT_CREDIT: begin
            if (credits_q != '0) begin
               take_credit = 1'b1;
               cnt_d       = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            net_enable_d               = 1'b1;
            net_index_d                = '0;
            net_index_d[CNT_W-1:0]     = cnt_q;
            net_value_d                = buffer_q[cnt_q];
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == IDLE) || (state_d == LOAD);
   end

   // A take and a return in the same cycle cancel; the clamp guards against a spurious pop.
   always_comb begin
      credits_d = credits_q;
      if (take_credit && !fifo_pop) begin
         credits_d = credits_q - CRED_W'(1);
      end else if (fifo_pop && !take_credit && (credits_q != FULL_CREDITS)) begin
         credits_d = credits_q + CRED_W'(1);
      end
      err_d = err_q || drop_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         credits_q    <= FULL_CREDITS;
         for (int i = 0; i < INPUT_AMOUNT; i++) begin
            buffer_q[i] <= '0;
         end
         in_ready_q   <= 1'b0;
         net_enable_q <= 1'b0;
         net_index_q  <= '0;
         net_value_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         credits_q    <= credits_d;
         buffer_q     <= buffer_d;
         in_ready_q   <= in_ready_d;
         net_enable_q <= net_enable_d;
         net_index_q  <= net_index_d;
         net_value_q  <= net_value_d;
         err_q        <= err_d;
      end
   end

   result_fifo #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(MAX_IN_FLIGHT)
   ) u_result_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_data(net_result[DATA_WIDTH-1:0]),
      .pop      (fifo_pop),
      .head_data(fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign in_ready       = in_ready_q;
   assign net_enable     = net_enable_q;
   assign net_index      = net_index_q;
   assign net_value      = net_value_q;
   assign out_valid      = !fifo_empty;
   assign out_class      = fifo_head;
   assign busy           = (state_q != IDLE) || (credits_q != FULL_CREDITS);
   assign err_unexpected = err_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Self-checking bench for inference_scheduler: a per-cycle vector table for the
// basic flows plus hand-written sequences for credit, FIFO and reset corners.
module tb_inference_scheduler;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [31:0] net_index;
   logic [31:0] net_value;
   logic        net_enable;
   logic [32:0] net_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_class;
   logic        busy;
   logic        err_unexpected;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic        in_valid;
      logic [31:0] in_value;
      logic        out_ready;
      logic [32:0] net_result;
      logic        exp_in_ready;
      logic        exp_net_enable;
      logic [31:0] exp_net_index;
      logic [31:0] exp_net_value;
      logic        exp_out_valid;
      logic [31:0] exp_out_class;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   int          burst_cnt;
   logic [31:0] burst_idx_q[$];
   logic [31:0] burst_val_q[$];

   inference_scheduler #(
      .DATA_WIDTH   (32),
      .INPUT_AMOUNT (4),
      .MAX_IN_FLIGHT(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_value      (in_value),
      .net_index     (net_index),
      .net_value     (net_value),
      .net_enable    (net_enable),
      .net_result    (net_result),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_class     (out_class),
      .busy          (busy),
      .err_unexpected(err_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every burst element seen on the layer-1 port, in order.
   initial burst_cnt = 0;
   always @(negedge clk) begin
      if (!rst && net_enable) begin
         burst_cnt++;
         burst_idx_q.push_back(net_index);
         burst_val_q.push_back(net_value);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic iv, input logic [31:0] val, input logic ordy,
                               input logic [32:0] nres, input logic rdy, input logic en,
                               input logic [31:0] idx, input logic [31:0] nval,
                               input logic ov, input logic [31:0] cls, input logic bsy);
      vec_t v;
      v.in_valid       = iv;
      v.in_value       = val;
      v.out_ready      = ordy;
      v.net_result     = nres;
      v.exp_in_ready   = rdy;
      v.exp_net_enable = en;
      v.exp_net_index  = idx;
      v.exp_net_value  = nval;
      v.exp_out_valid  = ov;
      v.exp_out_class  = cls;
      v.exp_busy       = bsy;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int n);
      @(negedge clk);
      in_valid   = v.in_valid;
      in_value   = v.in_value;
      out_ready  = v.out_ready;
      net_result = v.net_result;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d in_ready", n), 64'(in_ready), 64'(v.exp_in_ready));
      checkOutput($sformatf("vec%0d net_enable", n), 64'(net_enable), 64'(v.exp_net_enable));
      checkOutput($sformatf("vec%0d net_index", n), 64'(net_index), 64'(v.exp_net_index));
      checkOutput($sformatf("vec%0d net_value", n), 64'(net_value), 64'(v.exp_net_value));
      checkOutput($sformatf("vec%0d out_valid", n), 64'(out_valid), 64'(v.exp_out_valid));
      if (v.exp_out_valid) begin
         checkOutput($sformatf("vec%0d out_class", n), 64'(out_class), 64'(v.exp_out_class));
      end
      checkOutput($sformatf("vec%0d busy", n), 64'(busy), 64'(v.exp_busy));
      checkOutput($sformatf("vec%0d err", n), 64'(err_unexpected), 64'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_value   = '0;
      out_ready  = 1'b0;
      net_result = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds four elements base..base+3, each waiting (bounded) for in_ready.
   task automatic sendSample(input logic [31:0] base);
      int guard;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_value = base + 32'(i);
         guard    = 0;
         while (!in_ready && guard < 100) begin
            tick();
            guard++;
         end
         if (guard >= 100) begin
            checkOutput("send_timeout", 64'(in_ready), 64'd1);
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic waitBursts(input int target);
      int guard;
      guard = 0;
      while (burst_cnt < target && guard < 200) begin
         tick();
         guard++;
      end
      checkOutput("burst_wait", 64'(burst_cnt >= target), 64'd1);
      tick();
   endtask

   task automatic pushResult(input logic [31:0] cls);
      net_result = {1'b1, cls};
      tick();
      net_result = '0;
   endtask

   initial begin
      int          base;
      int          guard;
      logic [31:0] sample_base[3];

      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_value     = '0;
      out_ready    = 1'b0;
      net_result   = '0;

      // Single sample with in_valid held high, then a gapped sample of 2s.
      vecs.push_back(mk(0, 0, 0, 33'd0, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 33'd0, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 33'd0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 33'd0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 33'd0, 0, 1, 32'(i), 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 33'd0, 1, 1, 3, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 33'd0, 1, 0, 3, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, {1'b1, 32'd0}, 1, 0, 3, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 33'd0, 1, 0, 3, 1, 0, 0, 0));
      for (int i = 0; i < 6; i++) vecs.push_back(mk(i % 2 == 0, 2, 0, 33'd0, 1, 0, 3, 1, 0, 0, 1));
      vecs.push_back(mk(1, 2, 0, 33'd0, 0, 0, 3, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 33'd0, 0, 0, 3, 1, 0, 0, 1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 33'd0, 0, 1, 32'(i), 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 33'd0, 1, 1, 3, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 33'd0, 1, 0, 3, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, {1'b1, 32'd3}, 1, 0, 3, 2, 1, 3, 1));
      vecs.push_back(mk(0, 0, 1, 33'd0, 1, 0, 3, 2, 0, 0, 0));

      #12;
      rst = 1'b0;
      #1;
      checkOutput("reset in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset net_enable", 64'(net_enable), 64'd0);
      checkOutput("reset net_index", 64'(net_index), 64'd0);
      checkOutput("reset net_value", 64'(net_value), 64'd0);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_class", 64'(out_class), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset err", 64'(err_unexpected), 64'd0);

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Credit stall: three samples with no consumer; the third must wait.
      doReset();
      tick();
      base           = burst_cnt;
      sample_base[0] = 32'd10;
      sample_base[1] = 32'd20;
      sample_base[2] = 32'd30;
      sendSample(sample_base[0]);
      waitBursts(base + 4);
      pushResult(32'd7);
      sendSample(sample_base[1]);
      waitBursts(base + 8);
      pushResult(32'd8);
      sendSample(sample_base[2]);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("stall burst count", 64'(burst_cnt - base), 64'd8);
      checkOutput("stall in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall head", 64'(out_class), 64'd7);
      checkOutput("stall busy", 64'(busy), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("stall second head", 64'(out_class), 64'd8);
      waitBursts(base + 12);
      pushResult(32'd9);
      out_ready = 1'b1;
      checkOutput("stall pop 8", 64'(out_class), 64'd8);
      tick();
      checkOutput("stall pop 9", 64'(out_class), 64'd9);
      tick();
      out_ready = 1'b0;
      checkOutput("stall drained", 64'(out_valid), 64'd0);
      checkOutput("stall idle busy", 64'(busy), 64'd0);
      for (int i = 0; i < 12; i++) begin
         if (base + i < burst_idx_q.size()) begin
            checkOutput($sformatf("stall burst%0d index", i), 64'(burst_idx_q[base + i]), 64'(i % 4));
            checkOutput($sformatf("stall burst%0d value", i), 64'(burst_val_q[base + i]),
                        64'(sample_base[i / 4] + 32'(i % 4)));
         end else begin
            checkOutput($sformatf("stall burst%0d present", i), 64'd0, 64'd1);
         end
      end

      // Push and pop together on a full FIFO, then an overflowing push.
      doReset();
      tick();
      base = burst_cnt;
      sendSample(32'd40);
      waitBursts(base + 4);
      pushResult(32'd4);
      sendSample(32'd50);
      waitBursts(base + 8);
      pushResult(32'd5);
      checkOutput("full head", 64'(out_class), 64'd4);
      out_ready  = 1'b1;
      net_result = {1'b1, 32'd6};
      tick();
      out_ready  = 1'b0;
      net_result = '0;
      checkOutput("same-cycle head", 64'(out_class), 64'd5);
      checkOutput("same-cycle err", 64'(err_unexpected), 64'd0);
      pushResult(32'd7);
      checkOutput("overflow err", 64'(err_unexpected), 64'd1);
      out_ready = 1'b1;
      tick();
      checkOutput("overflow head 6", 64'(out_class), 64'd6);
      checkOutput("overflow valid", 64'(out_valid), 64'd1);
      tick();
      out_ready = 1'b0;
      checkOutput("overflow dropped", 64'(out_valid), 64'd0);

      // Stale result with nothing outstanding.
      doReset();
      tick();
      pushResult(32'd1);
      checkOutput("stale out_valid", 64'(out_valid), 64'd0);
      checkOutput("stale err", 64'(err_unexpected), 64'd1);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("stale err sticky", 64'(err_unexpected), 64'd1);
      doReset();
      #1;
      checkOutput("stale err cleared", 64'(err_unexpected), 64'd0);

      // Reset landing in the middle of a burst.
      tick();
      sendSample(32'd60);
      guard = 0;
      while (!(net_enable && net_index == 32'd2) && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput("midburst reached", 64'(guard < 100), 64'd1);
      base = burst_cnt;
      rst  = 1'b1;
      #1;
      checkOutput("midburst net_enable", 64'(net_enable), 64'd0);
      checkOutput("midburst in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      checkOutput("midburst release in_ready", 64'(in_ready), 64'd1);
      checkOutput("midburst release busy", 64'(busy), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("midburst no resume", 64'(burst_cnt - base), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
